// File: rtl/spi_exe_sched_pkg.sv
// Shared types and frame layout for the SPI exe-unit scheduler.
// Frame layout (MSB first): {argA, argB, oper} payload, then {result, flags}.
package spi_exe_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT_W,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DONE
  } state_t;

  localparam int ARG_W     = 4;
  localparam int PAYLOAD_W = 12;
  localparam int RES_LSB   = 4;
  localparam int FLG_LSB   = 0;

endpackage

// File: rtl/spi_exe_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; vld low when no request is pending.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] gnt,
  output logic                     vld
);

  localparam int IDW = $clog2(N_REQ);

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!vld && req[(int'(ptr) + i) % N_REQ]) begin
        vld = 1'b1;
        gnt = IDW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_exe_sched.sv
// Round-robin SPI master sharing spi_exe_unit slaves; write frame, GAP idle periods, read frame.
// Done (40+GAP) sclk periods + 1 clk after write start; requesters hold i_req until o_done. Echo compare: SPI_EXE_SCHED_ECHO_CHECK_EN.
module spi_exe_sched
  import spi_exe_sched_pkg::*;
#(
  parameter int BITS    = 20,
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [12*N_REQ-1:0]      i_args,
  input  logic [3*N_REQ-1:0]       i_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(N_REQ)-1:0] o_rsp_id,
  output logic [3:0]               o_result,
  output logic [3:0]               o_flags,
  output logic                     o_err,
  output logic                     o_sclk,
  output logic                     o_mosi,
  output logic [2:0]               o_cs,
  input  logic                     i_miso
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(((BITS > GAP) ? BITS : GAP) + 1);

  state_t                 state, state_nxt;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick, rise_tick, fall_tick, frame_end, gap_end;
  logic [CNT_W-1:0]       cnt;
  logic [BITS-1:0]        sh, cap;
  logic [2:0]             addr_q, sel_addr;
  logic [PAYLOAD_W-1:0]   sel_args;
  logic [IDW-1:0]         id_q, ptr, gnt;
  logic                   gnt_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (gnt),
    .vld (gnt_vld)
  );

  assign sel_addr  = i_addr[int'(gnt)*3 +: 3];
  assign sel_args  = i_args[int'(gnt)*PAYLOAD_W +: PAYLOAD_W];
  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = tick && !o_sclk;
  assign fall_tick = tick && o_sclk;
  // cnt holds rising edges seen in a frame; the frame closes on the falling edge after the last one
  assign frame_end = fall_tick && (cnt == CNT_W'(BITS));
  assign gap_end   = fall_tick && (cnt == CNT_W'(GAP - 1));
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt <= '0;
      o_sclk  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) o_sclk <= ~o_sclk;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|i_req) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!gnt_vld)              state_nxt = ST_IDLE;
        else if (sel_addr != 3'd0) state_nxt = ST_WAIT_W;
        else                       state_nxt = ST_DONE;
      end
      ST_WAIT_W: if (fall_tick) state_nxt = ST_WRITE;
      ST_WRITE:  if (frame_end) state_nxt = ST_GAP;
      ST_GAP:    if (gap_end)   state_nxt = ST_READ;
      ST_READ:   if (frame_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt      <= '0;
      sh       <= '0;
      cap      <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      ptr      <= '0;
      o_mosi   <= 1'b0;
      o_cs     <= 3'd0;
      o_done   <= 1'b0;
      o_rsp_id <= '0;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_ARB: if (gnt_vld) begin
          id_q   <= gnt;
          addr_q <= sel_addr;
          sh     <= {sel_args, {(BITS - PAYLOAD_W){1'b0}}};
          cap    <= '0;
          ptr    <= (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
        end
        ST_WAIT_W: if (fall_tick) begin
          o_cs   <= addr_q;
          o_mosi <= sh[BITS-1];
          sh     <= sh << 1;
          cnt    <= '0;
        end
        ST_WRITE: begin
          if (rise_tick) cnt <= cnt + CNT_W'(1);
          if (frame_end) begin
            o_cs   <= 3'd0;
            o_mosi <= 1'b0;
            cnt    <= '0;
          end else if (fall_tick) begin
            o_mosi <= sh[BITS-1];
            sh     <= sh << 1;
          end
        end
        ST_GAP: if (fall_tick) begin
          if (gap_end) begin
            o_cs <= addr_q;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (rise_tick) begin
            cap <= {cap[BITS-2:0], i_miso};
            cnt <= cnt + CNT_W'(1);
          end
          if (frame_end) o_cs <= 3'd0;
        end
        ST_DONE: begin
          o_done   <= 1'b1;
          o_rsp_id <= id_q;
          o_result <= cap[RES_LSB +: ARG_W];
          o_flags  <= cap[FLG_LSB +: ARG_W];
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_EXE_SCHED_ECHO_CHECK_EN
  logic [PAYLOAD_W-1:0] args_q;

  // addr=0 requests never touch the bus, so there is no echo to compare
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      args_q <= '0;
      o_err  <= 1'b0;
    end else begin
      if (state == ST_ARB && gnt_vld) args_q <= sel_args;
      o_err <= (state == ST_DONE) && (addr_q != 3'd0) &&
               (cap[BITS-1 -: PAYLOAD_W] != args_q);
    end
  end
`else
  logic unused_echo;
  assign unused_echo = ^cap[BITS-1 -: PAYLOAD_W];
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_exe_sched.sv
// Bench for spi_exe_sched: behavioural exe-unit slave plus round-robin order/result model.
module tb_spi_exe_sched;

  localparam int N_REQ   = 4;
  localparam int CLK_DIV = 2;
  localparam int GAP     = 3;
  localparam int BITS    = 20;
  localparam int LAT     = (2*BITS + GAP) * 2 * CLK_DIV + 1;
  localparam int CS_CYC  = 2 * BITS * 2 * CLK_DIV;
`ifdef SPI_EXE_SCHED_ECHO_CHECK_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [3:0]  i_req = '0;
  logic [47:0] i_args = '0;
  logic [11:0] i_addr = '0;
  logic        o_busy, o_done, o_err, o_sclk, o_mosi, i_miso;
  logic [1:0]  o_rsp_id;
  logic [3:0]  o_result, o_flags;
  logic [2:0]  o_cs;

  always #5 i_clk = ~i_clk;

  spi_exe_sched #(.BITS(BITS), .N_REQ(N_REQ), .CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_args(i_args), .i_addr(i_addr),
    .o_busy(o_busy), .o_done(o_done), .o_rsp_id(o_rsp_id), .o_result(o_result),
    .o_flags(o_flags), .o_err(o_err), .o_sclk(o_sclk), .o_mosi(o_mosi), .o_cs(o_cs),
    .i_miso(i_miso)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        corrupt_b = 1'b0;
  logic [11:0] req_args [N_REQ];
  logic [2:0]  req_addr [N_REQ];
  int          model_ptr = 0;

  // Slave behaviour: opcode 0 add, 1 sub, 2 and, 3 xor, else pass argA; flags {VF,PF,BF,OF}
  function automatic logic [7:0] slave_fn(input logic [11:0] p);
    logic [3:0] a, b, op, res;
    logic [4:0] s;
    a = p[11:8]; b = p[7:4]; op = p[3:0];
    case (op)
      4'd0:    s = {1'b0, a} + {1'b0, b};
      4'd1:    s = {1'b0, a} - {1'b0, b};
      4'd2:    s = {1'b0, a & b};
      4'd3:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    res = s[3:0];
    return {res, (op == 4'd0) && (a[3] == b[3]) && (res[3] != a[3]), ^res,
            (op == 4'd1) && (a < b), (op == 4'd0) && s[4]};
  endfunction

  logic [19:0] rx = '0, resp = '0, last_rx = '0;
  logic [2:0]  last_cs = '0;
  int          rx_n = 0, rd_n = 0;
  logic        rd_phase = 1'b0;

  always @(posedge o_sclk or negedge i_rst) begin
    if (!i_rst) begin
      rx_n = 0; rd_n = 0; rd_phase = 1'b0;
    end else if (o_cs != 3'd0) begin
      if (!rd_phase) begin
        rx = {rx[18:0], o_mosi};
        rx_n++;
        if (rx_n == BITS) begin
          last_rx  = rx;
          last_cs  = o_cs;
          resp     = {rx[19:8] ^ (corrupt_b ? 12'h010 : 12'h000), slave_fn(rx[19:8])};
          rd_phase = 1'b1;
          rx_n     = 0;
          rd_n     = 0;
        end
      end else begin
        rd_n++;
        if (rd_n == BITS) rd_phase = 1'b0;
      end
    end
  end

  assign i_miso = (rd_phase && rd_n < BITS) ? resp[19 - rd_n] : 1'b0;

  // MOSI must hold steady across every sclk rising edge
  logic mosi_prev = 1'b0;
  int   mosi_bad  = 0;
  always @(negedge i_clk) mosi_prev = o_mosi;
  always @(posedge o_sclk) if (i_rst && o_mosi !== mosi_prev) mosi_bad++;

  task automatic run_batch(input logic [3:0] mask, input string tag);
    int exp_q[$];
    logic [3:0] pend;
    logic [7:0] exp_rf;
    int p, got, cyc, cs_start, cs_cnt, budget, id;
    pend = mask; p = model_ptr;
    while (pend != 4'd0) begin
      for (int i = 0; i < N_REQ; i++) begin
        int j;
        j = (p + i) % N_REQ;
        if (pend[j]) begin
          exp_q.push_back(j); pend[j] = 1'b0; p = (j + 1) % N_REQ;
          break;
        end
      end
    end
    @(negedge i_clk);
    for (int k = 0; k < N_REQ; k++) begin
      i_args[12*k +: 12] = req_args[k];
      i_addr[3*k +: 3]   = req_addr[k];
    end
    i_req = i_req | mask;
    got = 0; cyc = 0; cs_start = -1; cs_cnt = 0;
    budget = exp_q.size() * (LAT + 40);
    while (got < exp_q.size() && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      if (o_cs != 3'd0) begin
        cs_cnt++;
        if (cs_start < 0) cs_start = cyc;
      end
      if (o_done) begin
        id = exp_q[got];
        exp_rf = (req_addr[id] != 3'd0) ? slave_fn(req_args[id]) : 8'h00;
        n_checks++;
        if (o_rsp_id !== 2'(id)) $display("FAIL %s rsp_id: got %0d want %0d", tag, o_rsp_id, id);
        else n_pass++;
        n_checks++;
        if ({o_result, o_flags} !== exp_rf)
          $display("FAIL %s result/flags: got %h want %h", tag, {o_result, o_flags}, exp_rf);
        else n_pass++;
        n_checks++;
        if (o_err !== (ECHO && corrupt_b && req_addr[id] != 3'd0))
          $display("FAIL %s o_err: got %b want %b", tag, o_err, ECHO && corrupt_b && req_addr[id] != 3'd0);
        else n_pass++;
        if (req_addr[id] != 3'd0) begin
          n_checks++;
          if (last_rx !== {req_args[id], 8'h00})
            $display("FAIL %s mosi frame: got %h want %h", tag, last_rx, {req_args[id], 8'h00});
          else n_pass++;
          n_checks++;
          if (last_cs !== req_addr[id]) $display("FAIL %s cs code: got %0d want %0d", tag, last_cs, req_addr[id]);
          else n_pass++;
          n_checks++;
          if (cyc - cs_start !== LAT) $display("FAIL %s latency: got %0d want %0d", tag, cyc - cs_start, LAT);
          else n_pass++;
          n_checks++;
          if (cs_cnt !== CS_CYC) $display("FAIL %s cs cycles: got %0d want %0d", tag, cs_cnt, CS_CYC);
          else n_pass++;
        end else begin
          n_checks++;
          if (cs_cnt !== 0) $display("FAIL %s addr0 cs activity: got %0d want 0", tag, cs_cnt);
          else n_pass++;
        end
        i_req[o_rsp_id] = 1'b0;
        model_ptr = (id + 1) % N_REQ;
        got++; cs_start = -1; cs_cnt = 0;
      end
    end
    n_checks++;
    if (got !== exp_q.size()) $display("FAIL %s completions: got %0d want %0d", tag, got, exp_q.size());
    else n_pass++;
    i_req = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    n_checks++; if (o_sclk !== 1'b0) $display("FAIL reset o_sclk: got %b want 0", o_sclk); else n_pass++;
    n_checks++; if (o_mosi !== 1'b0) $display("FAIL reset o_mosi: got %b want 0", o_mosi); else n_pass++;
    n_checks++; if (o_cs !== 3'd0) $display("FAIL reset o_cs: got %0d want 0", o_cs); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset o_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_done !== 1'b0) $display("FAIL reset o_done: got %b want 0", o_done); else n_pass++;
    n_checks++; if (o_rsp_id !== 2'd0) $display("FAIL reset o_rsp_id: got %0d want 0", o_rsp_id); else n_pass++;
    n_checks++; if (o_result !== 4'd0) $display("FAIL reset o_result: got %0d want 0", o_result); else n_pass++;
    n_checks++; if (o_flags !== 4'd0) $display("FAIL reset o_flags: got %0d want 0", o_flags); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL reset o_err: got %b want 0", o_err); else n_pass++;
    i_rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single();
    req_args[0] = 12'h350;
    req_addr[0] = 3'd1;
    run_batch(4'b0001, "single");
    n_checks++; if (last_rx !== 20'h35000) $display("FAIL single frame: got %h want 35000", last_rx); else n_pass++;
    n_checks++; if (o_result !== 4'd8) $display("FAIL single result: got %0d want 8", o_result); else n_pass++;
  endtask

  task automatic test_all_four();
    for (int k = 0; k < N_REQ; k++) begin
      req_args[k] = 12'($urandom);
      req_addr[k] = 3'($urandom_range(1, 7));
    end
    run_batch(4'b1111, "all4");
    run_batch(4'b0101, "reassert02");
  endtask

  task automatic test_addr0();
    req_args[1] = 12'h7A2;
    req_addr[1] = 3'd0;
    run_batch(4'b0010, "addr0");
  endtask

  task automatic test_reset_mid();
    int cyc, dones;
    req_args[3] = 12'($urandom);
    req_addr[3] = 3'd5;
    @(negedge i_clk);
    i_args[36 +: 12] = req_args[3];
    i_addr[9 +: 3]   = req_addr[3];
    i_req[3] = 1'b1;
    cyc = 0;
    while (!(rd_phase && o_cs != 3'd0) && cyc < 2*LAT) begin
      @(negedge i_clk);
      cyc++;
    end
    n_checks++;
    if (!(rd_phase && o_cs != 3'd0)) $display("FAIL rstmid reach read: got cyc %0d want read frame", cyc);
    else n_pass++;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_checks++; if (o_cs !== 3'd0) $display("FAIL rstmid o_cs: got %0d want 0", o_cs); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rstmid o_busy: got %b want 0", o_busy); else n_pass++;
    dones = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    i_rst = 1'b1;
    model_ptr = 0;
    n_checks++; if (dones !== 0) $display("FAIL rstmid o_done: got %0d pulses want 0", dones); else n_pass++;
    run_batch(4'b1000, "rstmid_retry");
  endtask

  task automatic test_echo();
    req_args[2] = 12'($urandom);
    req_addr[2] = 3'd6;
    corrupt_b = 1'b1;
    run_batch(4'b0100, "echo");
    corrupt_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < N_REQ; k++) begin
        req_args[k] = 12'($urandom);
        req_addr[k] = 3'($urandom_range(0, 7));
      end
      corrupt_b = 1'($urandom_range(0, 1));
      run_batch(4'($urandom_range(1, 15)), "random");
    end
    corrupt_b = 1'b0;
  endtask

  task automatic test_timing();
    n_checks++;
    if (mosi_bad !== 0) $display("FAIL mosi stability: got %0d changes at sclk rise want 0", mosi_bad);
    else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < N_REQ; k++) begin
      req_args[k] = '0;
      req_addr[k] = '0;
    end
    test_reset();
    test_single();
    test_all_four();
    test_addr0();
    test_reset_mid();
    test_echo();
    test_back_to_back();
    test_timing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_exe_sched.md
# spi_exe_sched

SPI master scheduler that shares up to seven `spi_exe_unit` slaves among `N_REQ` local requesters.

- Arbitrates requests round-robin.
- Serialises the winning `{argA,argB,oper}` into a 20-bit write frame on the addressed chip-select code.
- Keeps `o_sclk` running through the gap the slave needs to compute and reload its shifter.
- Clocks a 20-bit read frame back, then returns result and flags to the requester.

It sits between the system-clock domain and the SPI bus of the exe-unit slaves.

## Interface
- `BITS`, 20, frame length in bits.
- `N_REQ`, 4, number of requesters (2..8).
- `CLK_DIV`, 4, `i_clk` cycles per `o_sclk` half-period (≥2).
- `GAP`, 4, `o_sclk` periods with `o_cs`=0 between write and read frame (≥3).

- `i_clk`  in  1  system clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_req`  in  `N_REQ`  request per requester; held until its `o_done`.
- `i_args`  in  `12*N_REQ`  slice k = `{argA[3:0],argB[3:0],oper[3:0]}` at [12k+11:12k].
- `i_addr`  in  `3*N_REQ`  slice k = target chip-select code (1..7).
- `o_busy`  out  1  transaction in progress.
- `o_done`  out  1  one-`i_clk` completion pulse.
- `o_rsp_id`  out  `$clog2(N_REQ)`  requester index of completed transaction.
- `o_result`  out  4  slave result field.
- `o_flags`  out  4  slave flags `{VF,PF,BF,OF}`.
- `o_err`  out  1  echo mismatch (see Configuration).
- `o_sclk`  out  1  SPI clock, free-running.
- `o_mosi`  out  1  master data out.
- `o_cs`  out  3  chip-select code; 0 = none.
- `i_miso`  in  1  slave data in.

## Operation
- **Reset values:** `o_sclk`=0, `o_mosi`=0, `o_cs`=0, `o_busy`=0, `o_done`=0, `o_rsp_id`=0, `o_result`=0, `o_flags`=0, `o_err`=0. Round-robin pointer = 0. State = IDLE.
- **Reset mid-transaction:** abandons the transaction with no `o_done`. `o_cs` drops to 0 asynchronously.
- **`o_sclk`:** toggles every `CLK_DIV` `i_clk` cycles, always, from reset release. Slaves advance their state machines only on `o_sclk` edges.
- **States:**
  - IDLE → ARB when any `i_req`.
  - ARB: grant first set `i_req` at or after the pointer; latch args, addr, id; pointer = id+1 mod `N_REQ`.
    - addr≠0 → WAIT_W.
    - addr=0 → DONE with result=0, flags=0, no bus activity.
  - WAIT_W: wait for the next `o_sclk` falling edge → WRITE.
  - WRITE: `o_cs`=addr; shift `{argA,argB,oper,8'h00}` MSB first, 20 bits; → GAP after the 20th rising edge.
  - GAP: `o_cs`=0, `o_mosi`=0 for `GAP` full periods → READ.
  - READ: `o_cs`=addr, `o_mosi`=0; sample 20 bits MSB first into the capture register → DONE.
  - DONE: `o_result`=cap[7:4], `o_flags`=cap[3:0], `o_rsp_id`=id; pulse `o_done` → IDLE.
- **`o_busy`:** 1 from ARB through DONE inclusive.
- **Arbitration** occurs only in ARB. Requests arriving during a transaction wait.
- **Handshake:** a requester must drop `i_req` in the cycle after `o_done` for its id, or it is eligible again, behind the others.
- **Simultaneous requests:** lowest index at or after the pointer wins.
- **Pointer wrap:** after id `N_REQ-1` the pointer returns to 0.

## Timing
- `o_sclk` period = 2·`CLK_DIV` `i_clk` cycles.
- `o_mosi` and `o_cs` change only in the `i_clk` cycle that drives `o_sclk` falling.
- `i_miso` is sampled in the cycle that drives `o_sclk` rising.
- `o_cs` is asserted at a falling edge and held for exactly 20 rising edges, then released at the following falling edge.
- Latency from `o_sclk` falling edge entering WRITE to `o_done` is 40+`GAP` `o_sclk` periods plus 1 `i_clk`.
- Arbitration latency: `i_req` rise → ARB at +1 `i_clk`; WRITE start at ≤2·`CLK_DIV` further cycles.
- addr=0 request: `o_done` 2 `i_clk` after ARB.
- Back-to-back: a new ARB follows the `o_done` cycle (IDLE for 1 cycle).

## Configuration
- **`SPI_EXE_SCHED_ECHO_CHECK_EN` defined:** in DONE, compare cap[19:8] with the latched `{argA,argB,oper}`. `o_err` = mismatch, valid with `o_done`, 0 otherwise.
- **Undefined:** comparator not built; `o_err` tied 0.

## Structure
- **Package `spi_exe_sched_pkg`:**
  - State enum: IDLE, ARB, WAIT_W, WRITE, GAP, READ, DONE.
  - Field widths: `ARG_W`=4, `PAYLOAD_W`=12.
  - Frame bit offsets: argA 19:16, argB 15:12, oper 11:8, result 7:4, flags 3:0.
- **Sub-module `rr_arbiter` (`N_REQ`):**
  - Inputs: requests, pointer.
  - Outputs: grant index, valid.
  - Combinational.
- **Top-level:** clock divider, bit counter, shift/capture registers and FSM in the top module.

## Test plan
- Single request: req0, args `{3,5,ADD}`, addr 1, slave model adds. Required: `o_cs`=1 for 20 periods, MOSI `0x35x00` with x = ADD opcode; `o_done`, `o_rsp_id`=0, `o_result`=8, `o_flags` per slave.
- All four requests asserted together, pointer 0. Required: service order 0,1,2,3. Then re-assert 2 and 0 → order 2? No: pointer=0 after wrap, so order 0,2.
- addr=0 on req1. Required: no `o_cs` activity; `o_done` with `o_result`=0, `o_flags`=0.
- `i_rst` low during READ. Required: `o_cs`=0 immediately, no `o_done`. After release, a pending req completes normally.
- With the macro, slave model corrupts echoed argB. Required: `o_err`=1 with `o_done`. Without the macro, `o_err` stays 0.
- Timing check, `CLK_DIV`=2, `GAP`=3: `o_done` exactly 43 `o_sclk` periods + 1 `i_clk` after WRITE start. MOSI stable across every rising edge.
